// File: rtl/memory_pkg.sv
// Shared sizing constants for the scratch-storage block: RAM geometry and
// multiplier operand width.
package memory_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH      = 2 ** ADDR_W_DEF;

endpackage : memory_pkg

// File: rtl/memory_multiply_8.sv
// Registered unsigned byte multiplier: m = a[high byte] * a[low byte], one cycle
// latency, a new operand accepted every clock.
module multiply_8
   import memory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2*DATA_W-1:0] a,
   output logic [2*DATA_W-1:0] m
);

   logic [2*DATA_W-1:0] prod_p1;

   // Full-width product of two unsigned bytes; it cannot overflow 2*DATA_W bits.
   function automatic logic [2*DATA_W-1:0] umul(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
      logic [2*DATA_W-1:0] xw;
      logic [2*DATA_W-1:0] yw;
      xw = {{DATA_W{1'b0}}, x};
      yw = {{DATA_W{1'b0}}, y};
      return xw * yw;
   endfunction

   // stage p0 -> p1: operand sampled and product registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_p1 <= '0;
      end else begin
         prod_p1 <= umul(a[2*DATA_W-1:DATA_W], a[DATA_W-1:0]);
      end
   end

   assign m = prod_p1;

endmodule : multiply_8

// File: rtl/memory.sv
// Scratch storage: 16x8 single-port synchronous RAM on a shared tri-state bus,
// plus a registered byte multiplier running independently on the same clock.
module memory
   import memory_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic                oe,
   input  logic [ADDR_W-1:0]   addr,
   inout  wire  [DATA_W-1:0]   data,
   input  logic [2*DATA_W-1:0] a,
   output logic [2*DATA_W-1:0] m
);

   localparam int MEM_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic              drive_en;

   // Write and read are exclusive on an edge, so rd_q always sees pre-write contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_q <= '0;
      end else if (we) begin
         mem[addr] <= data;
      end else begin
         rd_q <= mem[addr];
      end
   end

   // Write has priority over output enable so the master never fights our driver.
   assign drive_en = oe && !we && rst_n;
   assign data     = drive_en ? rd_q : {DATA_W{1'bz}};

   multiply_8 #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .m     (m)
   );

endmodule : memory

// File: tb/tb_memory.sv
// Directed bench for memory: reset, RAM sweep, bus control, multiplier vectors
// and a reset pulse in the middle of a write burst.
module tb_memory;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic        oe;
   logic [3:0]  addr;
   wire  [7:0]  data;
   logic [15:0] a;
   logic [15:0] m;

   logic        tb_drv;
   logic [7:0]  tb_val;

   int n_cmp;
   int n_bad;

   assign data = tb_drv ? tb_val : 8'hzz;
   wire bus_z = (data === 8'hzz);

   memory dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .oe    (oe),
      .addr  (addr),
      .data  (data),
      .a     (a),
      .m     (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Multiplier vectors with hand-computed products.
   logic [15:0] op_tab  [7] = '{16'h0303, 16'h4444, 16'habcd, 16'h1e2f,
                                16'hFFFF, 16'h00FF, 16'h0101};
   logic [15:0] exp_tab [7] = '{16'h0009, 16'h1210, 16'h88EF, 16'h0582,
                                16'hFE01, 16'h0000, 16'h0001};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      we = 1'b0;
      oe = 1'b1;
      addr = 4'h0;
      a = 16'hFFFF;
      tb_drv = 1'b0;
      tb_val = 8'h00;

      #3;
      chk("rst_m", m, 16'h0000);
      chk("rst_busz", {15'b0, bus_z}, 16'h0001);

      @(negedge clk);
      rst_n = 1'b1;
      addr = 4'h5;
      a = 16'h0000;
      tick();
      chk("rst_rd5", {8'h00, data}, 16'h0000);
      chk("rst_rd5_drv", {15'b0, bus_z}, 16'h0000);

      // back-to-back multiplier operands
      for (int i = 0; i < 7; i++) begin
         a = op_tab[i];
         tick();
         chk($sformatf("mul%0d", i), m, exp_tab[i]);
      end

      // write sweep with the multiplier running alongside
      we = 1'b1;
      tb_drv = 1'b1;
      for (int i = 0; i < 16; i++) begin
         addr = 4'(i);
         tb_val = 8'(8'h11 * i);
         a = op_tab[i % 7];
         tick();
         chk($sformatf("wr_mul%0d", i), m, exp_tab[i % 7]);
      end

      // read sweep
      tb_drv = 1'b0;
      we = 1'b0;
      oe = 1'b1;
      for (int i = 0; i < 16; i++) begin
         addr = 4'(i);
         a = op_tab[(i + 3) % 7];
         tick();
         chk($sformatf("rd%0d", i), {8'h00, data}, {8'h00, 8'(8'h11 * i)});
         chk($sformatf("rd_mul%0d", i), m, exp_tab[(i + 3) % 7]);
      end

      // we=1 with oe=1: only the master drives
      we = 1'b1;
      oe = 1'b1;
      tb_drv = 1'b1;
      tb_val = 8'hA5;
      addr = 4'h3;
      #1;
      chk("we_oe_bus", {8'h00, data}, 16'h00A5);
      tick();
      chk("we_oe_bus2", {8'h00, data}, 16'h00A5);
      tb_drv = 1'b0;
      we = 1'b0;
      #1;
      chk("we_off_busz", {15'b0, bus_z}, 16'h0000);
      tick();
      chk("rdA5", {8'h00, data}, 16'h00A5);
      oe = 1'b0;
      #1;
      chk("oe0_busz", {15'b0, bus_z}, 16'h0001);
      addr = 4'h4;
      tick();
      chk("oe0_busz2", {15'b0, bus_z}, 16'h0001);
      oe = 1'b1;
      #1;
      chk("oe1_rd4", {8'h00, data}, 16'h0044);

      // reset pulse in the middle of a write burst
      we = 1'b1;
      tb_drv = 1'b1;
      tb_val = 8'h5A;
      for (int i = 0; i < 2; i++) begin
         addr = 4'(i);
         tick();
      end
      tb_drv = 1'b0;
      we = 1'b0;
      oe = 1'b1;
      addr = 4'h1;
      a = 16'habcd;
      tick();
      chk("burst_rd1", {8'h00, data}, 16'h005A);
      chk("burst_mul", m, 16'h88EF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_m", m, 16'h0000);
      chk("mid_rst_busz", {15'b0, bus_z}, 16'h0001);
      #2;
      rst_n = 1'b1;
      we = 1'b1;
      tb_drv = 1'b1;
      tb_val = 8'h77;
      addr = 4'h3;
      a = 16'h1e2f;
      tick();
      chk("post_rst_mul", m, 16'h0582);
      tb_drv = 1'b0;
      we = 1'b0;
      addr = 4'h0;
      tick();
      chk("post_rst_rd0", {8'h00, data}, 16'h0000);
      addr = 4'h1;
      tick();
      chk("post_rst_rd1", {8'h00, data}, 16'h0000);
      addr = 4'h5;
      tick();
      chk("post_rst_rd5", {8'h00, data}, 16'h0000);
      addr = 4'h3;
      tick();
      chk("post_rst_rd3", {8'h00, data}, 16'h0077);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_memory

// File: doc/memory.md
Name: memory

Overview:
- Small scratch-storage block for the timing-evaluation datapath.
- Contains a 16-entry x 8-bit single-port synchronous RAM with a shared bidirectional (tri-state) data bus.
- Contains a registered 8x8 byte multiplier that multiplies the high and low bytes of a 16-bit operand.
- Both functions share one clock and one asynchronous active-low reset.

Parameters:
- ADDR_W, 4, RAM address width (depth = 2**ADDR_W = 16).
- DATA_W, 8, RAM word width and multiplier operand byte width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable; 1 = bus drives data into RAM.
- oe  input  1  output enable; 1 with we=0 = RAM drives bus.
- addr  input  ADDR_W  RAM word address.
- data  inout  DATA_W  bidirectional RAM data bus.
- a  input  2*DATA_W  multiplier operand; a[15:8] x a[7:0].
- m  output  2*DATA_W  registered product.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 16 RAM words to 8'h00, read register rd_q to 8'h00, and m to 16'h0000.
  - The data bus is high-Z while rst_n is low.
- Write: at a rising clk with we=1, mem[addr] <= data. Single cycle, no handshake.
- Read:
  - At a rising clk with we=0, rd_q <= mem[addr]. Read latency is one cycle from the addr sample.
  - The value read is the contents before any write in the same edge; writes never occur together with a rd_q update.
- Bus drive:
  - data = rd_q when oe=1 and we=0; otherwise high-Z.
  - we=1 always forces the block's driver off (write has priority), so there is no contention when the external master drives.
- oe=0, we=0: rd_q still updates, but the bus floats.
- Address: all 16 addresses are valid; no wrap or out-of-range case exists.
- Multiplier:
  - At each rising clk, m <= a[15:8] * a[7:0], an unsigned 8x8 to 16-bit product.
  - Latency is 1 cycle, and a new operand is accepted every cycle.
  - Overflow is impossible (max 255*255 = 16'hFE01).
- Reset mid-operation: the effect is immediate regardless of clk. The first write/read/multiply occurs at the first rising clk after rst_n returns high.

Decomposition:
- Shared package: ADDR_W, DATA_W defaults and a DEPTH = 2**ADDR_W constant.
- One natural sub-module, multiply_8 (clk, rst_n, a[15:0] -> m[15:0] registered).
- The RAM array, read register and tri-state driver stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> m=16'h0000 and data=Z immediately; after release, read addr 4'h5 with oe=1 -> data=8'h00.
- Write/read sweep: write addr 0..F with 8'h00,8'h11,...,8'hFF (we=1, one per cycle); then we=0, oe=1, read 0..F -> data equals 8'h11*addr one cycle after each addr.
- Bus control:
  - we=1, oe=1 -> block never drives the bus; a written value 8'hA5 reads back 8'hA5.
  - oe=0, we=0 -> data=Z.
- Multiplier sequence: a=16'h0303 -> m=16'h0009; a=16'h4444 -> 16'h1210; a=16'habcd -> 16'h88EF; a=16'h1e2f -> 16'h0582. Each appears one clk after being applied, and back-to-back operands are accepted every cycle.
- Boundaries: a=16'hFFFF -> m=16'hFE01; a=16'h00FF -> 16'h0000; a=16'h0101 -> 16'h0001.
- Concurrency: multiplier and RAM traffic run simultaneously with no interference; rst_n pulse during a write burst clears the array, so subsequent reads return 8'h00 for unwritten addresses.
